// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// Sends one byte per request over the shared ps2Clk/ps2Data lines, using
// open-drain pull-low enables, and reports done/error with one-cycle pulses.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 2500,
  parameter int TIMEOUT_CYCLES = 375000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] txByte,
  input  logic       txStart,
  input  logic       ps2ClkIn,
  input  logic       ps2DataIn,
  output logic       ps2ClkDrvLow,
  output logic       ps2DataDrvLow,
  output logic       txBusy,
  output logic       txDone,
  output logic       txError
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INHIBIT   = 3'd1,
    S_RELEASE   = 3'd2,
    S_SEND      = 3'd3,
    S_ACK       = 3'd4,
    S_WAIT_IDLE = 3'd5,
    S_DONE      = 3'd6,
    S_ERROR     = 3'd7
  } state_t;

  // Odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

  logic [1:0]       clk_sync_q, data_sync_q;
  logic             clk_prev_q;
  logic             clk_s, data_s, fall;

  state_t           state_q, state_d;
  logic [9:0]       frame_q, frame_d;
  logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [WD_W-1:0]  wd_q, wd_d, wd_inc;
  logic             wd_expire;
  logic             clk_drv_q, clk_drv_d;
  logic             data_drv_q, data_drv_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  assign clk_s     = clk_sync_q[1];
  assign data_s    = data_sync_q[1];
  assign fall      = clk_prev_q & ~clk_s;
  assign wd_inc    = wd_q + WD_W'(1);
  assign wd_expire = (wd_inc == WD_LIMIT);

  // Synchronize both pins and keep the previous synced clock for fall detection
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2ClkIn};
      data_sync_q <= {data_sync_q[0], ps2DataIn};
      clk_prev_q  <= clk_sync_q[1];
    end
  end

  // Next-state and next-output logic; outputs are registered from these values
  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    inh_cnt_d  = inh_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    wd_d       = wd_q;
    clk_drv_d  = clk_drv_q;
    data_drv_d = data_drv_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        clk_drv_d  = 1'b0;
        data_drv_d = 1'b0;
        busy_d     = 1'b0;
        if (txStart) begin
          frame_d    = {1'b1, odd_parity(txByte), txByte};
          busy_d     = 1'b1;
          clk_drv_d  = 1'b1;
          // With a single inhibit cycle the start bit overlaps it at once
          data_drv_d = (INH_LAST == {INH_W{1'b0}}) ? 1'b1 : 1'b0;
          inh_cnt_d  = {INH_W{1'b0}};
          state_d    = S_INHIBIT;
        end else begin
          inh_cnt_d = {INH_W{1'b0}};
        end
      end
      S_INHIBIT: begin
        if (inh_cnt_q == INH_LAST) begin
          clk_drv_d  = 1'b0;
          data_drv_d = 1'b1;
          bit_cnt_d  = 4'd0;
          wd_d       = {WD_W{1'b0}};
          state_d    = S_RELEASE;
        end else begin
          inh_cnt_d  = inh_cnt_q + INH_W'(1);
          // Start bit goes low during the final inhibit cycle
          data_drv_d = (inh_cnt_q + INH_W'(1) == INH_LAST) ? 1'b1 : data_drv_q;
        end
      end
      S_RELEASE: begin
        bit_cnt_d = 4'd0;
        wd_d      = {WD_W{1'b0}};
        state_d   = S_SEND;
      end
      S_SEND: begin
        if (fall) begin
          data_drv_d = ~frame_q[bit_cnt_q];
          bit_cnt_d  = bit_cnt_q + 4'd1;
          wd_d       = {WD_W{1'b0}};
          state_d    = (bit_cnt_q == 4'd9) ? S_ACK : S_SEND;
        end else if (wd_expire) begin
          clk_drv_d  = 1'b0;
          data_drv_d = 1'b0;
          err_d      = 1'b1;
          wd_d       = {WD_W{1'b0}};
          state_d    = S_ERROR;
        end else begin
          wd_d = wd_inc;
        end
      end
      S_ACK: begin
        if (fall) begin
          wd_d = {WD_W{1'b0}};
          if (!data_s) begin
            state_d = S_WAIT_IDLE;
          end else begin
            clk_drv_d  = 1'b0;
            data_drv_d = 1'b0;
            err_d      = 1'b1;
            state_d    = S_ERROR;
          end
        end else if (wd_expire) begin
          clk_drv_d  = 1'b0;
          data_drv_d = 1'b0;
          err_d      = 1'b1;
          wd_d       = {WD_W{1'b0}};
          state_d    = S_ERROR;
        end else begin
          wd_d = wd_inc;
        end
      end
      S_WAIT_IDLE: begin
        if (clk_s && data_s) begin
          done_d  = 1'b1;
          wd_d    = {WD_W{1'b0}};
          state_d = S_DONE;
        end else if (fall) begin
          wd_d = {WD_W{1'b0}};
        end else if (wd_expire) begin
          clk_drv_d  = 1'b0;
          data_drv_d = 1'b0;
          err_d      = 1'b1;
          wd_d       = {WD_W{1'b0}};
          state_d    = S_ERROR;
        end else begin
          wd_d = wd_inc;
        end
      end
      S_DONE, S_ERROR: begin
        clk_drv_d  = 1'b0;
        data_drv_d = 1'b0;
        busy_d     = 1'b0;
        state_d    = S_IDLE;
      end
      default: begin
        clk_drv_d  = 1'b0;
        data_drv_d = 1'b0;
        busy_d     = 1'b0;
        state_d    = S_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; reset releases the lines at once
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      frame_q    <= 10'd0;
      inh_cnt_q  <= {INH_W{1'b0}};
      bit_cnt_q  <= 4'd0;
      wd_q       <= {WD_W{1'b0}};
      clk_drv_q  <= 1'b0;
      data_drv_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      inh_cnt_q  <= inh_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      wd_q       <= wd_d;
      clk_drv_q  <= clk_drv_d;
      data_drv_q <= data_drv_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign ps2ClkDrvLow  = clk_drv_q;
  assign ps2DataDrvLow = data_drv_q;
  assign txBusy        = busy_q;
  assign txDone        = done_q;
  assign txError       = err_q;

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter. It sends one command byte per request to the keyboard, for example 0xED (set LEDs) followed by its LED mask, or 0xFF (reset). It runs on the pixel clock beside the keyboard receiver and shares the ps2Clk/ps2Data lines through open-drain drive enables. While the block reports busy, the receiver ignores line activity.

## Interface
- INHIBIT_CYCLES, default 2500: clock-low inhibit time in cycles (100 µs at 25 MHz).
- TIMEOUT_CYCLES, default 375000: maximum cycles allowed between device clock falling edges (15 ms at 25 MHz).
- clock, input, 1: pixel clock; the block's only clock.
- reset, input, 1: asynchronous, active-high reset.
- txByte, input, 8: byte to send; captured when the request is accepted.
- txStart, input, 1: single-cycle request; accepted only in IDLE.
- ps2ClkIn, input, 1: raw ps2Clk pin level.
- ps2DataIn, input, 1: raw ps2Data pin level.
- ps2ClkDrvLow, output, 1: 1 pulls ps2Clk low; 0 releases it.
- ps2DataDrvLow, output, 1: 1 pulls ps2Data low; 0 releases it.
- txBusy, output, 1: high from acceptance until return to IDLE.
- txDone, output, 1: one-cycle pulse when the device acknowledges the byte.
- txError, output, 1: one-cycle pulse on missing acknowledge or timeout.

## Operation
- Input conditioning:
  - ps2ClkIn and ps2DataIn each pass through a 2-flop synchronizer.
  - A falling edge (fall) is a 1 in the previous synced clock sample followed by a 0 in the current one.
- Parity is odd: parity = ~^txByte.
- Shift frame is 10 bits: {stop=1, parity, txByte[7:0]}, LSB first.
- State machine:
  - IDLE: both drive enables 0, txBusy 0. On txStart: latch the frame, set txBusy, go to INHIBIT.
  - INHIBIT: ps2ClkDrvLow=1, counter runs 0..INHIBIT_CYCLES-1. In the last count, ps2DataDrvLow=1 (start bit). Then go to RELEASE.
  - RELEASE: ps2ClkDrvLow=0, ps2DataDrvLow=1, bit counter cleared. Go to SEND.
  - SEND: on each fall, ps2DataDrvLow = ~frame[bitCnt] and bitCnt increments.
    - Falls 1..8 present data bits 0..7.
    - Fall 9 presents parity.
    - Fall 10 releases data (stop bit).
    - After fall 10, go to ACK.
  - ACK: on the next fall (fall 11), sample synced data. 0 goes to WAIT_IDLE; 1 goes to ERROR.
  - WAIT_IDLE: wait until synced clock and synced data are both 1. Then pulse txDone and go to IDLE.
  - ERROR: release both lines, pulse txError, go to IDLE.
- Timeout:
  - In SEND, ACK and WAIT_IDLE, a watchdog counts cycles and clears on every fall.
  - Reaching TIMEOUT_CYCLES goes to ERROR.
  - The counter width must hold TIMEOUT_CYCLES.
- Boundary conditions:
  - txStart while txBusy is ignored, and txByte is not re-latched.
  - A fall coinciding with a timeout: the fall wins.
  - txDone and txError are never asserted together.
- Reset:
  - Asynchronous; immediately forces IDLE, both drive enables 0, and all counters 0.
  - Applies mid-frame as well. No done or error pulse follows a reset.

## Timing
- All outputs reset to 0.
- Acceptance: txStart high at cycle N gives txBusy=1 and ps2ClkDrvLow=1 at N+1.
- ps2ClkDrvLow stays high for exactly INHIBIT_CYCLES cycles.
- ps2DataDrvLow rises in the final inhibit cycle, so data is low 1 cycle before the clock is released.
- A pin falling edge is detected 3 cycles later: 2 sync stages plus the edge register. The data drive update is registered in that same cycle.
- txDone asserts 1 cycle after both lines read high in WAIT_IDLE.
- txError asserts 1 cycle after the failing condition.
- txBusy drops in the cycle after the done/error pulse. A new txStart is accepted from that cycle on.

## Test plan
- Normal send: txByte=0xED, a device model clocks 11 falls and drives ack low at fall 11.
  - Sampled bits must be 1,0,1,1,0,1,1,1, then parity 1, then stop 1.
  - One txDone pulse; txBusy low afterwards.
- Parity boundary: send 0x00 and expect parity 1; send 0x01 and expect parity 0; send 0xFF and expect parity 1.
- Missing ack: the model leaves data high at fall 11.
  - One txError pulse, no txDone, both drive enables 0.
- Timeout, using INHIBIT_CYCLES=20 and TIMEOUT_CYCLES=100:
  - The device never clocks.
  - txError fires 100 cycles after entering SEND; lines are released.
- txStart pulsed again mid-frame with txByte changed: the transmitted byte is unchanged, and only one txDone occurs.
- Reset asserted after fall 4:
  - Drive enables go to 0 within the same cycle.
  - txBusy goes to 0 and no pulses follow.
  - A subsequent 0xF4 send completes normally.
